instruction_fetch: RTL and testbench

Fetch stage directly upstream of the decoder. It owns the program counter, issues in-order word reads to instruction memory over a valid/ready request channel, and buffers returned words with their PCs in a small FIFO. It presents them to the decoder over a valid/ready handshake. Taken-branch and jump redirects from execute flush the buffer and discard all in-flight responses.

---
 rtl/instruction_fetch.sv | 73 +++++++
 tb/tb_instruction_fetch.sv | 132 +++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner issuing in-order imem word reads, buffering {word, pc} in a credit-limited FIFO for the decoder.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0]   CAP  = (CW+1)'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [31:0]   fetch_pc, resp_pc;
  logic [CW-1:0] outstanding, discard, count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   word_mem [DEPTH];
  logic [31:0]   pc_mem [DEPTH];
  logic          req_fire, keep, push, pop;
  // Responses return in order, so resp_pc shadows the address of the next kept response.
  always_comb begin
    inst_valid     = count != '0;
    imem_req_valid = !rst && !redirect_valid && ({1'b0, outstanding} + {1'b0, count} < CAP);
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    keep           = imem_resp_valid && discard == '0;
    push           = keep && !redirect_valid;
    pop            = inst_valid && inst_ready && !redirect_valid;
    instruction    = inst_valid ? word_mem[rd_ptr] : 32'h0000_0013;
    inst_pc        = inst_valid ? pc_mem[rd_ptr] : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= {redirect_pc[31:2], 2'b00};
      resp_pc     <= {redirect_pc[31:2], 2'b00};
      outstanding <= outstanding - CW'(imem_resp_valid);
      discard     <= outstanding - CW'(imem_resp_valid);
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (keep) resp_pc <= resp_pc + 32'd4;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
      if (imem_resp_valid && discard != '0) discard <= discard - CW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + PW'(1);
    end
  always_ff @(posedge clk)
    if (push) begin
      word_mem[wr_ptr] <= imem_resp_data;
      pc_mem[wr_ptr]   <= resp_pc;
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: random-latency in-order memory plus a transaction-level model of the fetch stream.
module tb_instruction_fetch;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int D = 3;
  logic clk = 0, rst = 0;
  logic imem_req_valid, imem_req_ready, imem_resp_valid, redirect_valid, inst_valid, inst_ready;
  logic [31:0] imem_req_addr, imem_resp_data, redirect_pc, instruction, inst_pc;
  always #5 clk = ~clk;
  instruction_fetch #(.RESET_PC(RPC), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction), .inst_pc(inst_pc)
  );
  typedef struct {logic [31:0] a; int due; bit stale;} mreq_t;
  typedef struct {logic [31:0] w; logic [31:0] pc;} ent_t;
  mreq_t mq[$];
  ent_t  fq[$];
  logic [31:0] nxt_pc;
  int cyc = 0, last_due = 0, lat_lo = 1, lat_hi = 1, npops = 0, errs = 0, checks = 0;
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input bit rv, input logic [31:0] rp, input bit rr, input bit ir);
    bit resp, exp_rv, hs, pop;
    int due;
    mreq_t m;
    redirect_valid = rv; redirect_pc = rp; imem_req_ready = rr; inst_ready = ir;
    resp = mq.size() > 0 && mq[0].due <= cyc;
    imem_resp_valid = resp;
    imem_resp_data = resp ? word_of(mq[0].a) : $urandom;
    #1;
    exp_rv = !rv && (mq.size() + fq.size() < D);
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    if (exp_rv) chk("req_addr", imem_req_addr, nxt_pc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, fq.size() != 0});
    if (fq.size() != 0) begin
      chk("instruction", instruction, fq[0].w);
      chk("inst_pc", inst_pc, fq[0].pc);
    end
    hs = exp_rv && rr;
    pop = fq.size() != 0 && ir && !rv;
    if (pop) npops++;
    @(posedge clk);
    if (pop) void'(fq.pop_front());
    if (resp) begin
      m = mq.pop_front();
      if (!m.stale && !rv) fq.push_back('{word_of(m.a), m.a});
    end
    if (hs) begin
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      mq.push_back('{nxt_pc, due, 1'b0});
      last_due = due;
      nxt_pc = nxt_pc + 32'd4;
    end
    if (rv) begin
      foreach (mq[i]) mq[i].stale = 1'b1;
      fq.delete();
      nxt_pc = {rp[31:2], 2'b00};
    end
    cyc++;
    #1;
  endtask
  task automatic do_reset();
    redirect_valid = 0; imem_resp_valid = 0; imem_req_ready = 0; inst_ready = 0;
    rst = 1;
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_instruction", instruction, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_req_addr", imem_req_addr, RPC);
    mq.delete(); fq.delete();
    nxt_pc = RPC;
    @(posedge clk);
    cyc++;
    last_due = cyc;
    #1;
    rst = 0;
  endtask
  initial begin
    redirect_valid = 0; redirect_pc = 0; imem_req_ready = 0; imem_resp_valid = 0;
    imem_resp_data = 0; inst_ready = 0;
    #2;
    do_reset();
    // streaming with 1-cycle memory, then a full-rate window
    for (int i = 0; i < 30; i++) step(0, 0, 1, 1);
    npops = 0;
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1);
    chk("throughput", 32'(npops), 32'd20);
    // decoder stall and release
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1);
    // 3-cycle latency redirect with requests in flight
    lat_lo = 3; lat_hi = 3;
    step(0, 0, 1, 1); step(0, 0, 1, 1);
    step(1, 32'h0000_2002, 1, 1);
    for (int i = 0; i < 15; i++) step(0, 0, 1, 1);
    // redirects landing on response cycles
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 60; i++)
      step(mq.size() > 0 && mq[0].due <= cyc && $urandom_range(1, 0) == 1, $urandom, 1, 1);
    // back-to-back redirects, last one wins
    step(1, 32'h0000_4000, 1, 1); step(1, 32'h0000_5001, 1, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1);
    // address wrap at the top of memory
    lat_lo = 1; lat_hi = 1;
    step(1, 32'hFFFF_FFFE, 1, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1);
    // random traffic
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 500; i++)
      step($urandom_range(19, 0) == 0, $urandom, $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);
    // fill the FIFO, then reset mid-stream
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 20 && fq.size() < D; i++) step(0, 0, 1, 0);
    chk("fifo_full_before_reset", {31'b0, inst_valid}, 32'd1);
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
